// File: rtl/tcbm_pkg.sv
// Shared TCBM command codes, status codes and device-link FSM states.
package tcbm_pkg;

   localparam logic [7:0] CMD_WRITE_CMD  = 8'h81;
   localparam logic [7:0] CMD_WRITE_DATA = 8'h83;
   localparam logic [7:0] CMD_READ_DATA  = 8'h84;

   localparam logic [1:0] ST_OK      = 2'b00;
   localparam logic [1:0] ST_EOI     = 2'b01;
   localparam logic [1:0] ST_TIMEOUT = 2'b10;
   localparam logic [1:0] ST_BADCMD  = 2'b11;

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_CMD_ACK  = 4'd1,
      S_CMD_REL  = 4'd2,
      S_WR_WAIT  = 4'd3,
      S_WR_PUSH  = 4'd4,
      S_WR_REL   = 4'd5,
      S_RD_WAIT  = 4'd6,
      S_RD_FETCH = 4'd7,
      S_RD_DRIVE = 4'd8,
      S_RD_ACK   = 4'd9
   } state_e;

   function automatic logic cmd_known(input logic [7:0] code);
      return (code == CMD_WRITE_CMD) || (code == CMD_WRITE_DATA) || (code == CMD_READ_DATA);
   endfunction

endpackage

// File: rtl/tcbm_sync.sv
// Multi-flop synchronizer for an asynchronous level; resets high so an idle-high strobe sees no edge.
module tcbm_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic [SYNC_STAGES-1:0] chain_q;
   logic [SYNC_STAGES-1:0] chain_d;

   always_comb begin
      chain_d = {chain_q[SYNC_STAGES-2:0], d};
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         chain_q <= '1;
      end else begin
         chain_q <= chain_d;
      end
   end

   assign q = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/tcbm_device_link.sv
// Device-side TCBM engine: 4-phase command+data handshakes with the host, bytes to/from rx/tx streams.
// Read-fetch timeout is built only when TCBM_LINK_TIMEOUT_EN is defined.
module tcbm_device_link
   import tcbm_pkg::*;
#(
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       dav_n,
   input  logic [7:0] pa_in,
   output logic [7:0] pa_out,
   output logic       pa_oe,
   output logic       ack_n,
   output logic [1:0] status,
   output logic [7:0] rx_data,
   output logic       rx_cmd,
   output logic       rx_valid,
   input  logic       rx_ready,
   input  logic [7:0] tx_data,
   input  logic       tx_last,
   input  logic       tx_valid,
   output logic       tx_ready
);

   state_e     state_q, state_d;
   logic [7:0] cmd_q, cmd_d;
   logic       ack_n_q, ack_n_d;
   logic       pa_oe_q, pa_oe_d;
   logic [7:0] pa_out_q, pa_out_d;
   logic [1:0] status_q, status_d;
   logic       rx_valid_q, rx_valid_d;
   logic [7:0] rx_data_q, rx_data_d;
   logic       rx_cmd_q, rx_cmd_d;
   logic       dav_s;
   logic       timeout_hit;

   tcbm_sync #(.SYNC_STAGES(SYNC_STAGES)) u_dav_sync (
      .clock (clock),
      .reset (reset),
      .d     (dav_n),
      .q     (dav_s)
   );

`ifdef TCBM_LINK_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Counter is cleared in every other state, so each fetch starts from zero.
   assign timeout_hit = (state_q == S_RD_FETCH) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      cnt_d = '0;
      if ((state_q == S_RD_FETCH) && !timeout_hit) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      cmd_d      = cmd_q;
      ack_n_d    = ack_n_q;
      pa_oe_d    = pa_oe_q;
      pa_out_d   = pa_out_q;
      status_d   = status_q;
      rx_valid_d = rx_valid_q;
      rx_data_d  = rx_data_q;
      rx_cmd_d   = rx_cmd_q;

      case (state_q)
         S_IDLE: begin
            if (!dav_s) begin
               cmd_d   = pa_in;
               state_d = S_CMD_ACK;
            end
         end
         S_CMD_ACK: begin
            ack_n_d  = 1'b0;
            status_d = cmd_known(cmd_q) ? ST_OK : ST_BADCMD;
            state_d  = S_CMD_REL;
         end
         S_CMD_REL: begin
            if (dav_s) begin
               ack_n_d = 1'b1;
               case (cmd_q)
                  CMD_WRITE_CMD, CMD_WRITE_DATA: state_d = S_WR_WAIT;
                  CMD_READ_DATA:                 state_d = S_RD_WAIT;
                  default:                       state_d = S_IDLE;
               endcase
            end
         end
         S_WR_WAIT: begin
            if (!dav_s) begin
               rx_data_d  = pa_in;
               rx_cmd_d   = (cmd_q == CMD_WRITE_CMD);
               rx_valid_d = 1'b1;
               state_d    = S_WR_PUSH;
            end
         end
         S_WR_PUSH: begin
            // ACK is withheld from the host until the sink takes the byte.
            if (rx_ready) begin
               rx_valid_d = 1'b0;
               ack_n_d    = 1'b0;
               state_d    = S_WR_REL;
            end
         end
         S_WR_REL: begin
            if (dav_s) begin
               ack_n_d = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_RD_WAIT: begin
            if (!dav_s) begin
               state_d = S_RD_FETCH;
            end
         end
         S_RD_FETCH: begin
            // A byte offered on the timeout cycle still wins over the timeout.
            if (tx_valid) begin
               pa_out_d = tx_data;
               status_d = tx_last ? ST_EOI : ST_OK;
               state_d  = S_RD_DRIVE;
            end else if (timeout_hit) begin
               pa_out_d = 8'h00;
               status_d = ST_TIMEOUT;
               state_d  = S_RD_DRIVE;
            end
         end
         S_RD_DRIVE: begin
            pa_oe_d = 1'b1;
            state_d = S_RD_ACK;
         end
         S_RD_ACK: begin
            if (ack_n_q) begin
               ack_n_d = 1'b0;
            end else if (dav_s) begin
               pa_oe_d = 1'b0;
               ack_n_d = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= S_IDLE;
         cmd_q      <= 8'h00;
         ack_n_q    <= 1'b1;
         pa_oe_q    <= 1'b0;
         pa_out_q   <= 8'h00;
         status_q   <= ST_OK;
         rx_valid_q <= 1'b0;
         rx_data_q  <= 8'h00;
         rx_cmd_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cmd_q      <= cmd_d;
         ack_n_q    <= ack_n_d;
         pa_oe_q    <= pa_oe_d;
         pa_out_q   <= pa_out_d;
         status_q   <= status_d;
         rx_valid_q <= rx_valid_d;
         rx_data_q  <= rx_data_d;
         rx_cmd_q   <= rx_cmd_d;
      end
   end

   assign ack_n    = ack_n_q;
   assign pa_oe    = pa_oe_q;
   assign pa_out   = pa_out_q;
   assign status   = status_q;
   assign rx_valid = rx_valid_q;
   assign rx_data  = rx_data_q;
   assign rx_cmd   = rx_cmd_q;
   assign tx_ready = (state_q == S_RD_FETCH);

endmodule

// File: tb/tb_tcbm_device_link.sv
// Randomized transaction-level bench for tcbm_device_link; timeout scenario runs when TCBM_LINK_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_tcbm_device_link;

   localparam int SS = 2;
   localparam int TO = 16;

   logic       clock = 1'b0;
   logic       reset;
   logic       dav_n;
   logic [7:0] pa_in;
   logic [7:0] pa_out;
   logic       pa_oe;
   logic       ack_n;
   logic [1:0] status;
   logic [7:0] rx_data;
   logic       rx_cmd;
   logic       rx_valid;
   logic       rx_ready;
   logic [7:0] tx_data;
   logic       tx_last;
   logic       tx_valid;
   logic       tx_ready;

   int errors = 0;
   int checks = 0;

   // Reference model: status the host should currently see, bytes the sink should receive, reads accepted.
   logic [1:0] exp_status = 2'b00;
   logic [8:0] rx_exp[$];
   logic [8:0] rx_got[$];
   int         tx_exp = 0;
   int         tx_acc = 0;

   tcbm_device_link #(.SYNC_STAGES(SS), .TIMEOUT_CYCLES(TO)) dut (
      .clock    (clock),
      .reset    (reset),
      .dav_n    (dav_n),
      .pa_in    (pa_in),
      .pa_out   (pa_out),
      .pa_oe    (pa_oe),
      .ack_n    (ack_n),
      .status   (status),
      .rx_data  (rx_data),
      .rx_cmd   (rx_cmd),
      .rx_valid (rx_valid),
      .rx_ready (rx_ready),
      .tx_data  (tx_data),
      .tx_last  (tx_last),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready)
   );

   always #5 clock = ~clock;

   always @(negedge clock) begin
      #2;
      if (!reset && rx_valid && rx_ready) rx_got.push_back({rx_cmd, rx_data});
      if (!reset && tx_valid && tx_ready) tx_acc++;
   end

   function automatic logic [1:0] spec_status(input logic [7:0] code);
      if (code == 8'h81 || code == 8'h83 || code == 8'h84) return 2'b00;
      return 2'b11;
   endfunction

   task automatic host_cmd(input logic [7:0] code);
      int n;
      @(negedge clock);
      checks++; if (status !== exp_status) begin errors++; $display("FAIL status_hold: got %b want %b", status, exp_status); end
      pa_in = code; dav_n = 1'b0; n = 0;
      while (n < 100) begin @(negedge clock); n++; if (ack_n === 1'b0) break; end
      checks++; if (n != SS + 2) begin errors++; $display("FAIL cmd_ack_latency code=%h: got %0d want %0d", code, n, SS + 2); end
      exp_status = spec_status(code);
      checks++; if (status !== exp_status) begin errors++; $display("FAIL cmd_status code=%h: got %b want %b", code, status, exp_status); end
      dav_n = 1'b1; n = 0;
      while (n < 100) begin @(negedge clock); n++; if (ack_n === 1'b1) break; end
      checks++; if (n != SS + 1) begin errors++; $display("FAIL cmd_rel_latency: got %0d want %0d", n, SS + 1); end
   endtask

   task automatic host_write(input logic [7:0] code, input logic [7:0] data, input int stall);
      int n;
      host_cmd(code);
      rx_ready = 1'b0;
      @(negedge clock);
      pa_in = data; dav_n = 1'b0; n = 0;
      while (n < 100) begin @(negedge clock); n++; if (rx_valid === 1'b1) break; end
      checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL rx_valid_rise: got %b want 1", rx_valid); end
      for (int i = 0; i < stall; i++) begin
         @(negedge clock);
         checks++; if ({ack_n, rx_valid, rx_cmd, rx_data} !== {2'b11, code == 8'h81, data})
            begin errors++; $display("FAIL wr_stall: got ack/vld/cmd/dat=%b%b%b/%h want 111/%h", ack_n, rx_valid, rx_cmd, rx_data, data); end
      end
      rx_ready = 1'b1;
      @(negedge clock);
      checks++; if ({ack_n, rx_valid} !== 2'b00) begin errors++; $display("FAIL wr_ack_after_accept: got ack=%b vld=%b want 0 0", ack_n, rx_valid); end
      rx_ready = 1'b0;
      rx_exp.push_back({code == 8'h81, data});
      dav_n = 1'b1; n = 0;
      while (n < 100) begin @(negedge clock); n++; if (ack_n === 1'b1) break; end
      checks++; if (n != SS + 1) begin errors++; $display("FAIL wr_rel_latency: got %0d want %0d", n, SS + 1); end
   endtask

   task automatic host_read(input logic [7:0] data, input logic last, input int delay);
      int n;
      host_cmd(8'h84);
      @(negedge clock);
      dav_n = 1'b0; n = 0;
      while (n < 100) begin @(negedge clock); n++; if (tx_ready === 1'b1) break; end
      checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL tx_ready_rise: got %b want 1", tx_ready); end
      for (int i = 0; i < delay; i++) begin
         @(negedge clock);
         checks++; if ({tx_ready, pa_oe, ack_n} !== 3'b101) begin errors++; $display("FAIL fetch_wait: got rdy/oe/ack=%b%b%b want 101", tx_ready, pa_oe, ack_n); end
      end
      tx_data = data; tx_last = last; tx_valid = 1'b1;
      @(negedge clock);
      tx_valid = 1'b0; tx_last = 1'b0;
      checks++; if ({tx_ready, pa_oe, ack_n} !== 3'b001) begin errors++; $display("FAIL fetch_done: got rdy/oe/ack=%b%b%b want 001", tx_ready, pa_oe, ack_n); end
      tx_exp++;
      @(negedge clock);
      checks++; if ({pa_oe, ack_n, pa_out} !== {2'b11, data}) begin errors++; $display("FAIL bus_driven: got oe/ack=%b%b out=%h want 11/%h", pa_oe, ack_n, pa_out, data); end
      @(negedge clock);
      exp_status = last ? 2'b01 : 2'b00;
      checks++; if ({pa_oe, ack_n, status} !== {2'b10, exp_status}) begin errors++; $display("FAIL rd_ack: got oe/ack=%b%b st=%b want 10/%b", pa_oe, ack_n, status, exp_status); end
      dav_n = 1'b1; n = 0;
      while (n < 100) begin @(negedge clock); n++; if (ack_n === 1'b1) break; end
      checks++; if (n != SS + 1) begin errors++; $display("FAIL rd_rel_latency: got %0d want %0d", n, SS + 1); end
      checks++; if (pa_oe !== 1'b0) begin errors++; $display("FAIL bus_released: got %b want 0", pa_oe); end
   endtask

   task automatic test_reset();
      reset = 1'b1; dav_n = 1'b1; pa_in = 8'h00; rx_ready = 1'b0;
      tx_data = 8'h00; tx_last = 1'b0; tx_valid = 1'b0;
      repeat (3) @(negedge clock);
      checks++; if ({ack_n, pa_oe, pa_out, status, rx_valid, rx_data, rx_cmd, tx_ready} !== {1'b1, 1'b0, 8'h00, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0})
         begin errors++; $display("FAIL reset_values: got ack=%b oe=%b out=%h st=%b vld=%b dat=%h cmd=%b rdy=%b", ack_n, pa_oe, pa_out, status, rx_valid, rx_data, rx_cmd, tx_ready); end
      reset = 1'b0;
      repeat (6) @(negedge clock);
      checks++; if ({ack_n, rx_valid, tx_ready} !== 3'b100) begin errors++; $display("FAIL idle_after_reset: got ack/vld/rdy=%b%b%b want 100", ack_n, rx_valid, tx_ready); end
   endtask

   task automatic test_write_cmd();
      host_write(8'h81, 8'h55, 0);
   endtask

   task automatic test_write_backpressure();
      host_write(8'h83, 8'hA7, 20);
   endtask

   task automatic test_read_eoi();
      host_read(8'h3C, 1'b1, 5);
   endtask

   task automatic test_read_stall();
`ifdef TCBM_LINK_TIMEOUT_EN
      int n;
      host_cmd(8'h84);
      @(negedge clock);
      dav_n = 1'b0; n = 0;
      while (n < 100) begin @(negedge clock); n++; if (tx_ready === 1'b1) break; end
      n = 0;
      while (tx_ready === 1'b1 && n < 1000) begin n++; @(negedge clock); end
      checks++; if (n != TO) begin errors++; $display("FAIL timeout_cycles: got %0d want %0d", n, TO); end
      @(negedge clock);
      checks++; if ({pa_oe, pa_out} !== {1'b1, 8'h00}) begin errors++; $display("FAIL timeout_bus: got oe=%b out=%h want 1/00", pa_oe, pa_out); end
      @(negedge clock);
      exp_status = 2'b10;
      checks++; if ({ack_n, status} !== 3'b010) begin errors++; $display("FAIL timeout_status: got ack=%b st=%b want 0/10", ack_n, status); end
      dav_n = 1'b1; n = 0;
      while (n < 100) begin @(negedge clock); n++; if (ack_n === 1'b1) break; end
      checks++; if ({ack_n, pa_oe} !== 2'b10) begin errors++; $display("FAIL timeout_release: got ack/oe=%b%b want 10", ack_n, pa_oe); end
`else
      host_read(8'hE1, 1'b0, 40);
`endif
   endtask

   task automatic test_bad_cmd();
      int rx_before;
      int tx_before;
      rx_before = rx_got.size();
      tx_before = tx_acc;
      host_cmd(8'h82);
      repeat (8) begin
         @(negedge clock);
         checks++; if ({rx_valid, tx_ready, ack_n} !== 3'b001) begin errors++; $display("FAIL bad_cmd_quiet: got vld/rdy/ack=%b%b%b want 001", rx_valid, tx_ready, ack_n); end
      end
      checks++; if (rx_got.size() != rx_before || tx_acc != tx_before) begin errors++; $display("FAIL bad_cmd_traffic: got rx=%0d tx=%0d want rx=%0d tx=%0d", rx_got.size(), tx_acc, rx_before, tx_before); end
   endtask

   task automatic test_reset_mid();
      int n;
      host_cmd(8'h84);
      @(negedge clock);
      dav_n = 1'b0; n = 0;
      while (n < 100) begin @(negedge clock); n++; if (tx_ready === 1'b1) break; end
      tx_data = 8'h99; tx_valid = 1'b1;
      @(negedge clock);
      tx_valid = 1'b0; tx_exp++; n = 0;
      while (n < 100) begin @(negedge clock); n++; if (ack_n === 1'b0) break; end
      checks++; if ({ack_n, pa_oe} !== 2'b01) begin errors++; $display("FAIL reach_rd_ack: got ack/oe=%b%b want 01", ack_n, pa_oe); end
      reset = 1'b1; dav_n = 1'b1;
      @(negedge clock);
      checks++; if ({ack_n, pa_oe, status} !== 4'b1000) begin errors++; $display("FAIL reset_in_rd_ack: got ack=%b oe=%b st=%b want 1 0 00", ack_n, pa_oe, status); end
      reset = 1'b0; exp_status = 2'b00;
      host_write(8'h81, 8'h12, 0);
      // Abort a write whose byte is still waiting on the sink.
      host_cmd(8'h83);
      @(negedge clock);
      pa_in = 8'h6D; dav_n = 1'b0; n = 0;
      while (n < 100) begin @(negedge clock); n++; if (rx_valid === 1'b1) break; end
      reset = 1'b1; dav_n = 1'b1;
      @(negedge clock);
      checks++; if ({rx_valid, ack_n, status} !== 4'b0100) begin errors++; $display("FAIL reset_in_wr_push: got vld=%b ack=%b st=%b want 0 1 00", rx_valid, ack_n, status); end
      reset = 1'b0; exp_status = 2'b00;
      repeat (4) @(negedge clock);
   endtask

   task automatic test_random();
      logic [7:0] code;
      for (int t = 0; t < 30; t++) begin
         case ($urandom_range(0, 3))
            0: host_write(8'h81, 8'($urandom), $urandom_range(0, 6));
            1: host_write(8'h83, 8'($urandom), $urandom_range(0, 6));
            2: host_read(8'($urandom), 1'($urandom), $urandom_range(0, 6));
            default: begin
               code = 8'($urandom);
               while (code == 8'h81 || code == 8'h83 || code == 8'h84) code = 8'($urandom);
               host_cmd(code);
            end
         endcase
      end
   endtask

   task automatic test_stream_totals();
      repeat (3) @(negedge clock);
      checks++; if (rx_got.size() != rx_exp.size()) begin errors++; $display("FAIL rx_count: got %0d want %0d", rx_got.size(), rx_exp.size()); end
      for (int i = 0; i < rx_exp.size() && i < rx_got.size(); i++) begin
         checks++; if (rx_got[i] !== rx_exp[i]) begin errors++; $display("FAIL rx_byte[%0d]: got cmd/dat=%h want %h", i, rx_got[i], rx_exp[i]); end
      end
      checks++; if (tx_acc != tx_exp) begin errors++; $display("FAIL tx_count: got %0d want %0d", tx_acc, tx_exp); end
   endtask

   initial begin
      test_reset();
      test_write_cmd();
      test_write_backpressure();
      test_read_eoi();
      test_read_stall();
      test_bad_cmd();
      test_reset_mid();
      test_random();
      test_stream_totals();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
